// File: rtl/arbitro_pkg.sv
// Shared types and constants for the round referee.
// Holds the FSM state encoding, the LFSR seed/taps and the LFSR step function.
package arbitro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    GO,
    RESULT
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci taps 16,14,13,11 expressed as bit indices.
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {s[14:0], fb};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge pulse generator.
// Ports: clock, reset (async, high), raw in; level (synced), rise (1-cycle pulse).
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic meta;
  logic prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= raw;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/arbitro_rodada.sv
// Round referee for the two-player reaction game: random delay, go light,
// winner/false-start decision. Ports: clock, reset, start, b1, b2, game_over
// in; go_led, p1vic, p2vic, busy out.
module arbitro_rodada
  import arbitro_pkg::*;
#(
  parameter int MIN_WAIT    = 100_000_000,
  parameter int RAND_SHIFT  = 11,
  parameter int GO_TIMEOUT  = 300_000_000,
  parameter int RESULT_HOLD = 50_000_000,
  parameter int CNT_W       = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic b1,
  input  logic b2,
  input  logic game_over,
  output logic go_led,
  output logic p1vic,
  output logic p2vic,
  output logic busy
);

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] delay;
  logic [15:0]      lfsr;
  logic             p1_nx;
  logic             p2_nx;

  logic st_lvl;
  logic st_rise;
  logic b1_lvl;
  logic b1_rise;
  logic b2_lvl;
  logic b2_rise;

  sync_edge u_start (
    .clock(clock),
    .reset(reset),
    .raw  (start),
    .level(st_lvl),
    .rise (st_rise)
  );

  sync_edge u_b1 (
    .clock(clock),
    .reset(reset),
    .raw  (b1),
    .level(b1_lvl),
    .rise (b1_rise)
  );

  sync_edge u_b2 (
    .clock(clock),
    .reset(reset),
    .raw  (b2),
    .level(b2_lvl),
    .rise (b2_rise)
  );

  // Sum is truncated to the counter width on purpose.
  assign delay = CNT_W'(MIN_WAIT)
               + (CNT_W'(lfsr) << RAND_SHIFT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p1vic <= 1'b0;
      p2vic <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      p1vic <= p1_nx;
      p2vic <= p2_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    p1_nx    = p1vic;
    p2_nx    = p2vic;
    unique case (state)
      IDLE: begin
        if (st_rise && !game_over) begin
          state_nx = ARM;
        end
      end
      ARM: begin
        if (game_over) begin
          state_nx = IDLE;
        end else if (!b1_lvl && !b2_lvl) begin
          cnt_nx   = delay;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (game_over) begin
          state_nx = IDLE;
        end else if (b1_rise || b2_rise) begin
          // Early press hands the point to the other player.
          state_nx = RESULT;
          cnt_nx   = CNT_W'(RESULT_HOLD);
          p1_nx    = b2_rise && !b1_rise;
          p2_nx    = b1_rise && !b2_rise;
        end else if (cnt == '0) begin
          state_nx = GO;
          cnt_nx   = CNT_W'(GO_TIMEOUT);
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      GO: begin
        if (game_over) begin
          state_nx = IDLE;
        end else if (b1_rise || b2_rise) begin
          state_nx = RESULT;
          cnt_nx   = CNT_W'(RESULT_HOLD);
          p1_nx    = b1_rise && !b2_rise;
          p2_nx    = b2_rise && !b1_rise;
        end else if (cnt == '0) begin
          state_nx = RESULT;
          cnt_nx   = CNT_W'(RESULT_HOLD);
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESULT: begin
        // Flag leaves on the edge that ends the hold.
        if (cnt <= CNT_W'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          p1_nx    = 1'b0;
          p2_nx    = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        p1_nx    = 1'b0;
        p2_nx    = 1'b0;
      end
    endcase
  end

  assign go_led = (state == GO);
  assign busy   = (state != IDLE);

endmodule

// File: doc/arbitro_rodada.md
Name: arbitro_rodada

Overview:
- Round referee for the two-player reaction game; it generates the p1vic/p2vic point levels consumed by the scoreboard.
- Runs one round per start press:
  - waits a pseudo-random delay, then lights go_led;
  - the first player to press after go wins the point;
  - a press before go is a false start and awards the point to the opponent.
- Sits between the debounced button conditioners and the scoreboard, and obeys the scoreboard's game_over.

Parameters:
- MIN_WAIT, 100_000_000: minimum cycles from round start to go_led.
- RAND_SHIFT, 11: random extra delay = lfsr[15:0] << RAND_SHIFT cycles.
- GO_TIMEOUT, 300_000_000: cycles in GO with no press before the round is voided.
- RESULT_HOLD, 50_000_000: cycles p1vic/p2vic stay high in RESULT.
- CNT_W, 32: width of the shared delay/timeout counter.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high.
- start, input, 1: debounced level; its rising edge starts a round.
- b1, input, 1: player 1 button, debounced level, asynchronous to clock.
- b2, input, 1: player 2 button, debounced level, asynchronous to clock.
- game_over, input, 1: from the scoreboard; when high, no rounds run.
- go_led, output, 1: high while in GO.
- p1vic, output, 1: high for RESULT_HOLD cycles when player 1 scores.
- p2vic, output, 1: high for RESULT_HOLD cycles when player 2 scores.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; counter 0; LFSR 16'hACE1.
  - synchronizer and edge registers 0.
- Inputs: start, b1 and b2 each pass through a 2-FF synchronizer, then a rising-edge detector (sync & ~sync_d).
  - A level applied before edge N is sampled at edge N; its edge pulse is valid during cycle N+2.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle, including in IDLE.
  - Never zero.
- IDLE:
  - start edge with game_over=0 -> ARM.
  - start edge while game_over=1 is ignored.
- ARM: waits until both synchronized buttons are low, then:
  - counter <= MIN_WAIT + (lfsr << RAND_SHIFT), truncated to CNT_W;
  - -> WAIT.
- WAIT: counter decrements each cycle.
  - b1 edge only -> RESULT, p2vic=1.
  - b2 edge only -> RESULT, p1vic=1.
  - b1 and b2 edges in the same cycle -> RESULT with neither flag set (void round).
  - Otherwise, counter==0 -> GO with counter <= GO_TIMEOUT.
  - Any button edge takes priority over counter expiry in the same cycle.
- GO: go_led=1; counter decrements each cycle.
  - b1 edge only -> RESULT, p1vic=1.
  - b2 edge only -> RESULT, p2vic=1.
  - Both edges in the same cycle -> RESULT, void.
  - counter==0 with no edge -> RESULT, void.
- RESULT:
  - counter <= RESULT_HOLD on entry.
  - The vic flag set on entry is registered and held for exactly RESULT_HOLD cycles.
  - Then flags clear -> IDLE.
  - p1vic and p2vic are never high simultaneously.
  - The flag falls before the next round can start, which guarantees a fresh rising edge for the scoreboard.
- Timing: p1vic/p2vic and go_led are registered outputs that change in the cycle after the decision edge.
  - Button level to vic high = 3 clock edges.
- Ignored inputs:
  - start edges in any non-IDLE state.
  - b1/b2 edges in IDLE, ARM and RESULT.
- game_over=1 in ARM, WAIT or GO aborts to IDLE with go_led=0.
  - game_over does not cut a RESULT hold short; the 7th point must reach the scoreboard.
- Asynchronous reset mid-round returns to IDLE immediately, with all outputs 0.

Decomposition:
- Package arbitro_pkg holds:
  - state enum {IDLE, ARM, WAIT, GO, RESULT};
  - LFSR seed 16'hACE1 and tap constants.
- One sub-module, sync_edge: 2-FF synchronizer plus rising-edge pulse, instantiated three times (start, b1, b2).
- FSM, counter and LFSR stay in the top module.

Test Plan (MIN_WAIT=10, RAND_SHIFT=0, GO_TIMEOUT=20, RESULT_HOLD=4):
- Normal win: start pulse, wait for go_led, raise b1 -> p1vic high 3 edges later for exactly 4 cycles, go_led low, then IDLE with busy=0.
- False start: start, raise b2 before go_led -> p1vic high 4 cycles; go_led never asserts.
- Simultaneous: b1 and b2 raised on the same edge during GO -> neither vic asserts, busy drops after 4 cycles; repeat in WAIT with the same result.
- Timeout: start and no presses -> go_led high for 21 cycles, then falls; no vic; IDLE.
- Game over:
  - start while game_over=1 -> stays IDLE;
  - game_over raised in WAIT -> IDLE next cycle;
  - game_over raised during RESULT -> vic still held 4 cycles.
- Reset mid-GO: assert reset asynchronously -> go_led, vic and busy all 0 immediately; a b1 held across reset deassertion does not start a round, and ARM waits for its release.
